// File: rtl/line_buf_rotation_ctrl.sv
// Rotation controller for a bank of WIN_SIZE+1 line buffers: write pointer, read window mask, pop strobes.
// Optional READ watchdog is enabled by defining LINE_BUF_ROTATION_CTRL_WATCHDOG_EN.
module line_buf_rotation_ctrl #(
    parameter int WIN_SIZE = 3,
    parameter int TIMEOUT  = 16384
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_line_end_i,
    input  logic                          wr_frame_start_i,
    input  logic                          wr_frame_end_i,
    input  logic                          rd_line_done_i,
    output logic [WIN_SIZE:0]             wr_buf_sel_o,
    output logic [WIN_SIZE:0]             rd_buf_mask_o,
    output logic [WIN_SIZE:0]             pop_o,
    output logic [$clog2(WIN_SIZE+1)-1:0] oldest_idx_o,
    output logic                          frame_done_o,
    output logic                          overflow_o,
    output logic                          timeout_o
);

    localparam int NB = WIN_SIZE + 1;
    localparam int IW = $clog2(NB);
    localparam int LW = $clog2(NB + 1);
    localparam logic [LW-1:0]   FULL     = LW'(NB);
    localparam logic [LW-1:0]   WIN      = LW'(WIN_SIZE);
    localparam logic [WIN_SIZE:0] SEL_RST  = {{WIN_SIZE{1'b0}}, 1'b1};
    localparam logic [WIN_SIZE:0] MASK_RST = {1'b0, {WIN_SIZE{1'b1}}};

    typedef enum logic [2:0] {IDLE, FILL, RUN, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lines_q, lines_d;
    logic [WIN_SIZE:0] sel_q, sel_d;
    logic [WIN_SIZE:0] mask_q, mask_d;
    logic [WIN_SIZE:0] pop_q, pop_d;
    logic [IW-1:0]     oldest_q, oldest_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              pending_q, pending_d;
    logic              wd_fire;
    logic              line_acc;
    logic              rd_done;

    function automatic logic [WIN_SIZE:0] rotl(input logic [WIN_SIZE:0] v);
        return {v[WIN_SIZE-1:0], v[WIN_SIZE]};
    endfunction

`ifdef LINE_BUF_ROTATION_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != READ || wr_frame_start_i || rd_line_done_i || wd_fire)
            wd_cnt_q <= '0;
        else
            wd_cnt_q <= wd_cnt_q + CW'(1);
    end

    assign wd_fire = (state_q == READ) && !rd_line_done_i && (wd_cnt_q == CW'(TIMEOUT - 1));
`else
    // TIMEOUT only has meaning when the watchdog is built in
    assign wd_fire = 1'b0 && (TIMEOUT > 0);
`endif

    assign line_acc = wr_line_end_i && ((state_q != IDLE) || wr_frame_start_i);
    assign rd_done  = (state_q == READ) && (rd_line_done_i || wd_fire);

    always_comb begin
        state_d   = state_q;
        lines_d   = lines_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        oldest_d  = oldest_q;
        pop_d     = '0;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        pending_d = pending_q;

        if (wr_frame_start_i) begin
            state_d   = FILL;
            lines_d   = wr_line_end_i ? LW'(1) : '0;
            sel_d     = wr_line_end_i ? rotl(SEL_RST) : SEL_RST;
            mask_d    = MASK_RST;
            oldest_d  = '0;
            pending_d = 1'b0;
        end else begin
            if (line_acc) begin
                sel_d = rotl(sel_q);
                if (lines_q == FULL)
                    ovf_d = 1'b1;
            end
            if (line_acc && !rd_done)
                lines_d = (lines_q == FULL) ? FULL : lines_q + LW'(1);
            else if (rd_done && !line_acc)
                lines_d = (lines_q == '0) ? '0 : lines_q - LW'(1);
            if (rd_done) begin
                mask_d   = rotl(mask_q);
                oldest_d = (oldest_q == IW'(WIN_SIZE)) ? '0 : oldest_q + IW'(1);
                if (wd_fire)
                    tmo_d = 1'b1;
            end

            case (state_q)
                IDLE: ;
                FILL: begin
                    if (wr_frame_end_i)
                        state_d = DRAIN;
                    else if (lines_d >= WIN)
                        state_d = RUN;
                end
                RUN: begin
                    if (lines_q >= WIN) begin
                        pop_d     = mask_q;
                        state_d   = READ;
                        pending_d = wr_frame_end_i;
                    end else if (wr_frame_end_i) begin
                        state_d = DRAIN;
                    end
                end
                READ: begin
                    if (wr_frame_end_i)
                        pending_d = 1'b1;
                    if (rd_done) begin
                        state_d   = (pending_q || wr_frame_end_i) ? DRAIN : RUN;
                        pending_d = 1'b0;
                    end
                end
                DRAIN: begin
                    // Keep popping full windows until too few lines remain, then close the frame
                    if (lines_q >= WIN) begin
                        pop_d     = mask_q;
                        state_d   = READ;
                        pending_d = 1'b1;
                    end else begin
                        done_d   = 1'b1;
                        state_d  = IDLE;
                        lines_d  = '0;
                        sel_d    = SEL_RST;
                        mask_d   = MASK_RST;
                        oldest_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lines_q   <= '0;
            sel_q     <= SEL_RST;
            mask_q    <= MASK_RST;
            oldest_q  <= '0;
            pop_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lines_q   <= lines_d;
            sel_q     <= sel_d;
            mask_q    <= mask_d;
            oldest_q  <= oldest_d;
            pop_q     <= pop_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            pending_q <= pending_d;
        end
    end

    assign wr_buf_sel_o  = sel_q;
    assign rd_buf_mask_o = mask_q;
    assign pop_o         = pop_q;
    assign oldest_idx_o  = oldest_q;
    assign frame_done_o  = done_q;
    assign overflow_o    = ovf_q;
    assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_line_buf_rotation_ctrl.sv
// Directed, table-driven bench for line_buf_rotation_ctrl with WIN_SIZE=3, TIMEOUT=8.
module tb_line_buf_rotation_ctrl;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] LE   = 4'b1000;
    localparam logic [3:0] FS   = 4'b0100;
    localparam logic [3:0] LEFE = 4'b1010;
    localparam logic [3:0] RD   = 4'b0001;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       wr_line_end_i = 1'b0;
    logic       wr_frame_start_i = 1'b0;
    logic       wr_frame_end_i = 1'b0;
    logic       rd_line_done_i = 1'b0;
    logic [3:0] wr_buf_sel_o;
    logic [3:0] rd_buf_mask_o;
    logic [3:0] pop_o;
    logic [1:0] oldest_idx_o;
    logic       frame_done_o;
    logic       overflow_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;

    line_buf_rotation_ctrl #(.WIN_SIZE(3), .TIMEOUT(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wr_line_end_i    (wr_line_end_i),
        .wr_frame_start_i (wr_frame_start_i),
        .wr_frame_end_i   (wr_frame_end_i),
        .rd_line_done_i   (rd_line_done_i),
        .wr_buf_sel_o     (wr_buf_sel_o),
        .rd_buf_mask_o    (rd_buf_mask_o),
        .pop_o            (pop_o),
        .oldest_idx_o     (oldest_idx_o),
        .frame_done_o     (frame_done_o),
        .overflow_o       (overflow_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] stim;
        logic [3:0] exp_sel;
        logic [3:0] exp_mask;
        logic [3:0] exp_pop;
        logic [1:0] exp_old;
        logic       exp_done;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [3:0] stim, input logic [3:0] sel, input logic [3:0] mask,
                                input logic [3:0] pop, input logic [1:0] old, input logic done,
                                input logic ovf);
        vec_t v;
        v.stim = stim; v.exp_sel = sel; v.exp_mask = mask; v.exp_pop = pop;
        v.exp_old = old; v.exp_done = done; v.exp_ovf = ovf;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are held for one rising edge and outputs sampled 1 time unit later
    task automatic apply_stimulus(input logic [3:0] stim);
        {wr_line_end_i, wr_frame_start_i, wr_frame_end_i, rd_line_done_i} = stim;
        @(posedge clk_i);
        #1;
        {wr_line_end_i, wr_frame_start_i, wr_frame_end_i, rd_line_done_i} = NONE;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic fill_and_pop();
        apply_stimulus(FS);
        repeat (3) apply_stimulus(LE);
        apply_stimulus(NONE);
    endtask

    initial begin
        vecs[0]  = mk(LE,   4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(FS,   4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[2]  = mk(LE,   4'b0010, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[3]  = mk(LE,   4'b0100, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[4]  = mk(LE,   4'b1000, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[5]  = mk(NONE, 4'b1000, 4'b0111, 4'b0111, 2'd0, 1'b0, 1'b0);
        vecs[6]  = mk(NONE, 4'b1000, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[7]  = mk(RD,   4'b1000, 4'b1110, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[8]  = mk(LE,   4'b0001, 4'b1110, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[9]  = mk(NONE, 4'b0001, 4'b1110, 4'b1110, 2'd1, 1'b0, 1'b0);
        vecs[10] = mk(NONE, 4'b0001, 4'b1110, 4'b0000, 2'd1, 1'b0, 1'b0);
        vecs[11] = mk(RD,   4'b0001, 4'b1101, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[12] = mk(LEFE, 4'b0010, 4'b1101, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[13] = mk(NONE, 4'b0010, 4'b1101, 4'b1101, 2'd2, 1'b0, 1'b0);
        vecs[14] = mk(NONE, 4'b0010, 4'b1101, 4'b0000, 2'd2, 1'b0, 1'b0);
        vecs[15] = mk(RD,   4'b0010, 4'b1011, 4'b0000, 2'd3, 1'b0, 1'b0);
        vecs[16] = mk(NONE, 4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b1, 1'b0);
        vecs[17] = mk(NONE, 4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[18] = mk(RD,   4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
        vecs[19] = mk(LE,   4'b0001, 4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);

        do_reset();
        check_output("reset sel", 32'(wr_buf_sel_o), 32'h1);
        check_output("reset mask", 32'(rd_buf_mask_o), 32'h7);
        check_output("reset pop", 32'(pop_o), 32'h0);
        check_output("reset oldest", 32'(oldest_idx_o), 32'h0);
        check_output("reset done", 32'(frame_done_o), 32'h0);
        check_output("reset ovf", 32'(overflow_o), 32'h0);
        check_output("reset tmo", 32'(timeout_o), 32'h0);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i].stim);
            check_output($sformatf("row%0d sel", i), 32'(wr_buf_sel_o), 32'(vecs[i].exp_sel));
            check_output($sformatf("row%0d mask", i), 32'(rd_buf_mask_o), 32'(vecs[i].exp_mask));
            check_output($sformatf("row%0d pop", i), 32'(pop_o), 32'(vecs[i].exp_pop));
            check_output($sformatf("row%0d oldest", i), 32'(oldest_idx_o), 32'(vecs[i].exp_old));
            check_output($sformatf("row%0d done", i), 32'(frame_done_o), 32'(vecs[i].exp_done));
            check_output($sformatf("row%0d ovf", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
            check_output($sformatf("row%0d tmo", i), 32'(timeout_o), 32'h0);
        end

        // Overflow: five line ends with no read completion
        do_reset();
        apply_stimulus(FS);
        repeat (4) apply_stimulus(LE);
        check_output("ovf after 4", 32'(overflow_o), 32'h0);
        check_output("sel after 4", 32'(wr_buf_sel_o), 32'h1);
        apply_stimulus(LE);
        check_output("ovf after 5", 32'(overflow_o), 32'h1);
        check_output("sel after 5", 32'(wr_buf_sel_o), 32'h2);
        apply_stimulus(FS);
        check_output("ovf sticky", 32'(overflow_o), 32'h1);
        check_output("sel after restart", 32'(wr_buf_sel_o), 32'h1);

        // Frame start while a read is pending
        do_reset();
        fill_and_pop();
        check_output("abort pop", 32'(pop_o), 32'h7);
        apply_stimulus(FS);
        check_output("abort mask", 32'(rd_buf_mask_o), 32'h7);
        check_output("abort oldest", 32'(oldest_idx_o), 32'h0);
        check_output("abort sel", 32'(wr_buf_sel_o), 32'h1);
        apply_stimulus(RD);
        check_output("late rd mask", 32'(rd_buf_mask_o), 32'h7);
        check_output("late rd oldest", 32'(oldest_idx_o), 32'h0);
        repeat (2) apply_stimulus(LE);
        apply_stimulus(NONE);
        check_output("refill 2 no pop", 32'(pop_o), 32'h0);
        apply_stimulus(LE);
        apply_stimulus(NONE);
        check_output("refill 3 pop", 32'(pop_o), 32'h7);

        // Reset in the middle of READ, with a coincident read completion
        do_reset();
        fill_and_pop();
        rst_i = 1'b1;
        apply_stimulus(RD);
        rst_i = 1'b0;
        check_output("rst mid mask", 32'(rd_buf_mask_o), 32'h7);
        check_output("rst mid oldest", 32'(oldest_idx_o), 32'h0);
        check_output("rst mid sel", 32'(wr_buf_sel_o), 32'h1);
        apply_stimulus(NONE);
        check_output("rst mid pop", 32'(pop_o), 32'h0);
        apply_stimulus(RD);
        check_output("rst mid idle rd", 32'(rd_buf_mask_o), 32'h7);

        // Watchdog: no read completion after a pop
        do_reset();
        fill_and_pop();
        check_output("wd pop", 32'(pop_o), 32'h7);
        repeat (7) apply_stimulus(NONE);
        check_output("wd tmo at 7", 32'(timeout_o), 32'h0);
        check_output("wd mask at 7", 32'(rd_buf_mask_o), 32'h7);
        apply_stimulus(NONE);
`ifdef LINE_BUF_ROTATION_CTRL_WATCHDOG_EN
        check_output("wd tmo at 8", 32'(timeout_o), 32'h1);
        check_output("wd mask at 8", 32'(rd_buf_mask_o), 32'he);
        check_output("wd oldest at 8", 32'(oldest_idx_o), 32'h1);
`else
        check_output("wd tmo at 8", 32'(timeout_o), 32'h0);
        check_output("wd mask at 8", 32'(rd_buf_mask_o), 32'h7);
        check_output("wd oldest at 8", 32'(oldest_idx_o), 32'h0);
        repeat (20) apply_stimulus(NONE);
        check_output("wd still waiting", 32'(rd_buf_mask_o), 32'h7);
        apply_stimulus(RD);
        check_output("wd late rd mask", 32'(rd_buf_mask_o), 32'he);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_buf_rotation_ctrl.md
LINE_BUF_ROTATION_CTRL -- requirements
Module: line_buf_rotation_ctrl

Interface
REQ-001 SHALL have parameter WIN_SIZE, default 3: window height in lines; the controlled bank has WIN_SIZE+1 line buffers.
REQ-002 SHALL have parameter TIMEOUT, default 16384: watchdog limit in clocks (used only per REQ-026).
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_line_end_i  input  1  one-cycle pulse: a complete line has been written to the selected buffer.
REQ-006 SHALL have port wr_frame_start_i  input  1  one-cycle pulse: first beat of a frame.
REQ-007 SHALL have port wr_frame_end_i  input  1  one-cycle pulse: last beat of a frame; coincides with wr_line_end_i.
REQ-008 SHALL have port rd_line_done_i  input  1  one-cycle pulse: the window path has finished reading the popped lines.
REQ-009 SHALL have port wr_buf_sel_o  output  WIN_SIZE+1  one-hot write-buffer select.
REQ-010 SHALL have port rd_buf_mask_o  output  WIN_SIZE+1  exactly WIN_SIZE ones; buffers forming the current window.
REQ-011 SHALL have port pop_o  output  WIN_SIZE+1  one-cycle pop strobe to the masked buffers.
REQ-012 SHALL have port oldest_idx_o  output  $clog2(WIN_SIZE+1)  index of the oldest masked buffer (top window row).
REQ-013 SHALL have port frame_done_o  output  1  one-cycle pulse when frame drain completes.
REQ-014 SHALL have port overflow_o  output  1  sticky flag: write into a full bank.
REQ-015 SHALL have port timeout_o  output  1  sticky watchdog flag; constant 0 when the watchdog is compiled out.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, RUN, READ, DRAIN.
REQ-017 SHALL keep lines_stored, range 0..WIN_SIZE+1: +1 on accepted wr_line_end_i, -1 on rd_line_done_i in READ, unchanged when both occur in the same cycle, saturating at both ends.
REQ-018 SHALL rotate wr_buf_sel_o circularly left by one on each accepted wr_line_end_i; bit WIN_SIZE wraps to bit 0.
REQ-019 SHALL ignore wr_line_end_i in IDLE unless it coincides with wr_frame_start_i.
REQ-020 SHALL, on wr_frame_start_i in any state, clear lines_stored, wr_buf_sel_o, rd_buf_mask_o and oldest_idx_o to their reset values, abort any pending read, and enter FILL; a coincident wr_line_end_i is then counted (lines_stored=1, wr_buf_sel_o rotated once).
REQ-021 SHALL go FILL->RUN when lines_stored reaches WIN_SIZE; in RUN or DRAIN with lines_stored>=WIN_SIZE, SHALL drive pop_o=rd_buf_mask_o for exactly one cycle, registered one clock after the condition holds, and enter READ.
REQ-022 SHALL, on rd_line_done_i in READ, rotate rd_buf_mask_o circularly left by one, increment oldest_idx_o modulo WIN_SIZE+1, and return to RUN (or DRAIN if a frame end is pending); SHALL ignore rd_line_done_i in other states.
REQ-023 SHALL set overflow_o when wr_line_end_i is accepted with lines_stored==WIN_SIZE+1; the write pointer still rotates and lines_stored stays saturated.
REQ-024 SHALL, on wr_frame_end_i, enter DRAIN after any in-progress READ; in DRAIN, once lines_stored<WIN_SIZE and no read is pending, SHALL pulse frame_done_o for one cycle, clear lines_stored and pointers to reset values, and enter IDLE.

Reset
REQ-025 SHALL, with rst_i high at a clock edge, set state=IDLE, lines_stored=0, wr_buf_sel_o=1, rd_buf_mask_o=2^WIN_SIZE-1, oldest_idx_o=0, pop_o=0, frame_done_o=0, overflow_o=0, timeout_o=0, watchdog counter=0; reset mid-READ drops the pending read with no pop and no rotation.

Configuration
REQ-026 SHALL, with macro LINE_BUF_ROTATION_CTRL_WATCHDOG_EN defined, count cycles in READ; on reaching TIMEOUT without rd_line_done_i, SHALL set timeout_o and act as if rd_line_done_i had arrived; without the macro, no counter exists and READ waits indefinitely.

Verification (WIN_SIZE=3)
REQ-027 SHALL cover: frame_start + 3 line ends -> pop_o=4'b0111 one cycle after 3rd line end; wr_buf_sel_o=4'b1000.
REQ-028 SHALL cover: rd_line_done_i after first pop -> rd_buf_mask_o=4'b1110, oldest_idx_o=1; 4th line stored -> second pop 4'b1110.
REQ-029 SHALL cover: 5 line ends with no rd_line_done_i -> overflow_o=1 on 5th, lines_stored=4, wr_buf_sel_o wrapped to 4'b0010.
REQ-030 SHALL cover: wr_frame_end_i with lines_stored=3 -> one final pop, then rd_line_done_i -> frame_done_o pulse, outputs at reset values, state IDLE.
REQ-031 SHALL cover: wr_frame_start_i while in READ -> no rotation, lines_stored=0, FILL; a later rd_line_done_i has no effect.
REQ-032 SHALL cover: with watchdog enabled and TIMEOUT=8, pop then no rd_line_done_i -> timeout_o=1 after 8 cycles, rd_buf_mask_o rotated; with macro undefined -> stays in READ, timeout_o=0.
